// File: rtl/grey_counter.sv
// Twelve-digit decimal counter with one Johnson-coded register per digit and a muxed display bus.
// Define GREY_SANITIZE_EN to force invalid Johnson codes (at reset load or at run time) to zero.
module grey_counter (
  input  logic [7:0]  io_in,
  input  logic [59:0] init,
  output logic [4:0]  ones,
  output logic [4:0]  tens,
  output logic [4:0]  hund,
  output logic [4:0]  thou,
  output logic [4:0]  tenT,
  output logic [4:0]  hunT,
  output logic [4:0]  mil,
  output logic [4:0]  tenM,
  output logic [4:0]  hunM,
  output logic [4:0]  bil,
  output logic [4:0]  tenB,
  output logic [4:0]  hunB,
  output logic [7:0]  io_out
);

  localparam int         NumDigits = 12;
  localparam logic [4:0] CodeNine  = 5'b10000;

  logic       clk;
  logic       rst_n;
  logic [3:0] dsel;
  logic       hold;
  logic       mode;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign dsel  = io_in[5:2];
  assign hold  = io_in[6];
  assign mode  = io_in[7];

  logic [NumDigits-1:0][4:0] digit_q;
  logic [NumDigits-1:0][4:0] digit_d;
  logic [NumDigits-1:0][4:0] init_load;
  logic [NumDigits:0]        carry;
  logic                      all_nine;
  logic [4:0]                sel_code;

  function automatic logic [4:0] johnson_inc(input logic [4:0] q);
    return {q[3:0], ~q[4]};
  endfunction

  function automatic logic code_valid(input logic [4:0] q);
    logic ok;
    case (q)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Active-high segments, bit 0 = a ... bit 6 = g; invalid codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [4:0] q);
    logic [6:0] seg;
    case (q)
      5'b00000: seg = 7'h3F;
      5'b00001: seg = 7'h06;
      5'b00011: seg = 7'h5B;
      5'b00111: seg = 7'h4F;
      5'b01111: seg = 7'h66;
      5'b11111: seg = 7'h6D;
      5'b11110: seg = 7'h7D;
      5'b11100: seg = 7'h07;
      5'b11000: seg = 7'h7F;
      5'b10000: seg = 7'h6F;
      default:  seg = 7'h40;
    endcase
    return seg;
  endfunction

  always_comb begin
    init_load = '0;
    for (int k = 0; k < NumDigits; k++) begin
`ifdef GREY_SANITIZE_EN
      init_load[k] = code_valid(init[5*k +: 5]) ? init[5*k +: 5] : 5'b00000;
`else
      init_load[k] = init[5*k +: 5];
`endif
    end
  end

  // Carry into digit k is the AND of "digit j is nine" for every lower digit, all on one edge.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int k = 0; k < NumDigits; k++) begin
      carry[k+1] = carry[k] & (digit_q[k] == CodeNine);
    end
  end

  assign all_nine = carry[NumDigits];

  always_comb begin
    digit_d = digit_q;
    for (int k = 0; k < NumDigits; k++) begin
      if (!hold && carry[k]) begin
        digit_d[k] = johnson_inc(digit_q[k]);
      end
`ifdef GREY_SANITIZE_EN
      // Scrubbing wins over both hold and any incoming carry.
      if (!code_valid(digit_q[k])) begin
        digit_d[k] = 5'b00000;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= init_load;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign ones = digit_q[0];
  assign tens = digit_q[1];
  assign hund = digit_q[2];
  assign thou = digit_q[3];
  assign tenT = digit_q[4];
  assign hunT = digit_q[5];
  assign mil  = digit_q[6];
  assign tenM = digit_q[7];
  assign hunM = digit_q[8];
  assign bil  = digit_q[9];
  assign tenB = digit_q[10];
  assign hunB = digit_q[11];

  always_comb begin
    sel_code = 5'b00000;
    for (int k = 0; k < NumDigits; k++) begin
      if (dsel == 4'(k)) begin
        sel_code = digit_q[k];
      end
    end
    io_out = 8'h00;
    if (dsel < 4'(NumDigits)) begin
      if (mode) begin
        io_out = {3'b000, sel_code};
      end else begin
        io_out = {all_nine, seg_decode(sel_code)};
      end
    end
  end

`ifndef GREY_SANITIZE_EN
  logic unused_valid;
  assign unused_valid = code_valid(5'b00000);
`endif

endmodule

// File: tb/tb_grey_counter.sv
// Directed plus randomized bench for grey_counter against a decimal-integer reference model.
module tb_grey_counter;

  localparam longint unsigned Modulus = 64'd1000000000000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  sel   = 6'h00;
  logic [59:0] init  = '0;
  logic [7:0]  io_in;
  logic [4:0]  ones, tens, hund, thou, tenT, hunT, mil, tenM, hunM, bil, tenB, hunB;
  logic [7:0]  io_out;
  logic [59:0] dut_vec;

  assign io_in   = {sel, rst_n, clk};
  assign dut_vec = {hunB, tenB, bil, hunM, tenM, mil, hunT, tenT, thou, hund, tens, ones};

  grey_counter dut (
    .io_in  (io_in),
    .init   (init),
    .ones   (ones),
    .tens   (tens),
    .hund   (hund),
    .thou   (thou),
    .tenT   (tenT),
    .hunT   (hunT),
    .mil    (mil),
    .tenM   (tenM),
    .hunM   (hunM),
    .bil    (bil),
    .tenB   (tenB),
    .hunB   (hunB),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  longint unsigned count    = 0;
  longint unsigned init_val = 0;

  logic [4:0] j_tab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                             5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int digit_of(input longint unsigned v, input int k);
    longint unsigned t = v;
    for (int i = 0; i < k; i++) t = t / 10;
    return int'(t % 10);
  endfunction

  function automatic logic [59:0] code_vec(input longint unsigned v);
    logic [59:0] r = '0;
    for (int k = 0; k < 12; k++) r[5*k +: 5] = j_tab[digit_of(v, k)];
    return r;
  endfunction

  function automatic logic [7:0] exp_out(input longint unsigned v, input logic [5:0] s);
    int idx = int'(s[3:0]);
    int d;
    if (idx >= 12) return 8'h00;
    d = digit_of(v, idx);
    if (s[5]) return {3'b000, j_tab[d]};
    return {(v == Modulus - 1), seg_tab[d]};
  endfunction

  function automatic longint unsigned rand_val();
    longint unsigned v = 0;
    for (int k = 0; k < 12; k++) begin
      v = v * 10 + (($urandom_range(0, 1) == 1) ? 64'd9 : longint'($urandom_range(0, 9)));
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_init(input longint unsigned v);
    init_val = v;
    init     = code_vec(v);
  endtask

  // One rising edge; the model advances from the inputs that were stable at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) count = init_val;
    else if (!sel[4]) count = (count + 1) % Modulus;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_digits"}, 64'(dut_vec), 64'(code_vec(count)));
    check({tag, "_io"}, 64'(io_out), 64'(exp_out(count, sel)));
  endtask

  initial begin
    logic [59:0] frozen;

    // 1: reset to zero
    set_init(0);
    rst_n = 1'b0;
    sel   = 6'h00;
    tick();
    check_state("t1");
    check("t1_seg0", 64'(io_out), 64'h3F);

    // 2: ten counts, ones wraps and carries into tens
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      check_state("t2");
    end
    check("t2_tens", 64'(tens), 64'(5'b00001));
    check("t2_ones", 64'(ones), 64'(5'b00000));
    sel = 6'h01;
    #1;
    check("t2_sel1", 64'(io_out), 64'h06);

    // 3: 99 -> 100
    sel = 6'h00;
    set_init(99);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_state("t3");
    check("t3_hund", 64'(hund), 64'(5'b00001));
    check("t3_thou", 64'(thou), 64'(5'b00000));

    // 4: terminal count flag and full wrap
    set_init(Modulus - 1);
    rst_n = 1'b0;
    tick();
    check("t4_flag", 64'(io_out), 64'hEF);
    rst_n = 1'b1;
    tick();
    check_state("t4_wrap");
    check("t4_seg0", 64'(io_out), 64'h3F);

    // 5: hold, raw mode, out-of-range select
    tick();
    tick();
    frozen = dut_vec;
    sel = 6'h10;
    repeat (5) begin
      tick();
      check_state("t5_hold");
    end
    check("t5_frozen", 64'(dut_vec), 64'(frozen));
    sel = 6'h21;
    #1;
    check("t5_raw", 64'(io_out), 64'(exp_out(count, sel)));
    sel = 6'h0C;
    #1;
    check("t5_blank", 64'(io_out), 64'h00);

    // 6: reset mid-count loads ones=3, then counting resumes
    sel = 6'h00;
    set_init(3);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("t6_load", 64'(ones), 64'(5'b00111));
    rst_n = 1'b1;
    tick();
    check("t6_resume", 64'(ones), 64'(5'b01111));
    check_state("t6");

    // Invalid init code for the ones digit
    init  = 60'h0A;
    rst_n = 1'b0;
    tick();
`ifdef GREY_SANITIZE_EN
    check("inv_load", 64'(dut_vec), 64'h0);
    rst_n = 1'b1;
    tick();
    check("inv_count", 64'(dut_vec), 64'h01);
`else
    check("inv_load", 64'(dut_vec), 64'h0A);
    check("inv_dash", 64'(io_out), 64'h40);
    rst_n = 1'b1;
    tick();
    check("inv_shift", 64'(dut_vec), 64'h15);
`endif

    // Resynchronise the model, then random traffic
    set_init(0);
    rst_n = 1'b0;
    tick();
    check_state("resync");
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      if (!rst_n) set_init(rand_val());
      sel = 6'($urandom_range(0, 63));
      if (sel[4] && $urandom_range(0, 1) == 1) sel[4] = 1'b0;
      tick();
      check_state("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
